strobe_arbiter: RTL and testbench

- Shares one edge-gated write strobe between NREQ requesters, e.g. register-file or memory write ports built around the positive-edge pulse generator.
- Round-robin arbitration; a four-phase req/ack handshake per requester.
- Drives the pulse generator's enable so exactly one 3-gate-delay pulse fires per granted transfer.
- Muxes the winner's data onto the shared write bus and holds it stable around the pulse.

---
 rtl/strobe_arbiter_if.sv | 24 ++
 rtl/strobe_arbiter.sv | 120 ++++++++++++
 tb/tb_strobe_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/strobe_arbiter_if.sv
// Request/grant/strobe bundle between requesters and the shared-strobe arbiter.
// slave is the arbiter side; master is the requester side.
interface strobe_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      dout;
  logic                  strobe_en;
  logic                  busy;

  modport master (
    output req, din,
    input  gnt, ack, dout, strobe_en, busy
  );

  modport slave (
    input  req, din,
    output gnt, ack, dout, strobe_en, busy
  );
endinterface

// File: rtl/strobe_arbiter.sv
// Round-robin arbiter sharing one edge-gated write strobe among NREQ requesters.
// Each transfer walks GRANT (setup), STROBE (pulse enable), ACK (hold) and RELEASE.
module strobe_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  strobe_arbiter_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = IW + 1;

  typedef enum logic [2:0] {StIdle, StGrant, StStrobe, StAck, StRelease} state_e;

  state_e           r_state, w_state_d;
  logic [IW-1:0]    r_ptr, w_ptr_d;
  logic [IW-1:0]    r_idx, w_idx_d;
  logic [NREQ-1:0]  r_gnt, w_gnt_d;
  logic [NREQ-1:0]  r_ack, w_ack_d;
  logic [WIDTH-1:0] r_dout, w_dout_d;
  logic             r_strobe_en, w_strobe_en_d;
  logic             r_busy, w_busy_d;

  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [PW-1:0]    w_pos;
  logic [IW-1:0]    w_cand;

  // Scan ptr, ptr+1, ... modulo NREQ; the first asserted request wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_pos   = '0;
    w_cand  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_pos = PW'(r_ptr) + PW'(k);
      if (w_pos >= PW'(NREQ)) begin
        w_pos = w_pos - PW'(NREQ);
      end
      w_cand = w_pos[IW-1:0];
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_idx_d       = r_idx;
    w_gnt_d       = r_gnt;
    w_ack_d       = '0;
    w_dout_d      = r_dout;
    w_strobe_en_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_gnt_d = '0;
        if (w_found) begin
          w_state_d        = StGrant;
          w_idx_d          = w_pick;
          w_gnt_d[w_pick]  = 1'b1;
          w_dout_d         = bus.din[int'(w_pick)*WIDTH +: WIDTH];
        end
      end
      StGrant: begin
        w_state_d     = StStrobe;
        w_strobe_en_d = 1'b1;
      end
      StStrobe: begin
        w_state_d = StAck;
        w_ack_d   = r_gnt;
      end
      StAck: begin
        w_state_d = StRelease;
        w_gnt_d   = '0;
        w_ptr_d   = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
      end
      StRelease: begin
        // Holding off re-arbitration until the winner drops req prevents a double strobe.
        if (!bus.req[r_idx]) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_dout      <= '0;
      r_strobe_en <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_idx       <= w_idx_d;
      r_gnt       <= w_gnt_d;
      r_ack       <= w_ack_d;
      r_dout      <= w_dout_d;
      r_strobe_en <= w_strobe_en_d;
      r_busy      <= w_busy_d;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.ack       = r_ack;
  assign bus.dout      = r_dout;
  assign bus.strobe_en = r_strobe_en;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_strobe_arbiter.sv
// Directed bench for strobe_arbiter: handshake timing, round-robin order, hold, reset.
// Pulses are counted on every rising edge that ends a cycle with strobe_en high.
module tb_strobe_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   pulse_cnt;
  logic [7:0] last_pulse;
  logic prev_se;

  strobe_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  strobe_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.strobe_en === 1'b1) begin
      pulse_cnt  = pulse_cnt + 1;
      last_pulse = bus.dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_tests >= 0) begin
      check_eq("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check_eq("ack_in_gnt", 32'(bus.ack & ~bus.gnt), 32'd0);
      check_eq("strobe_2cyc", 32'(prev_se & bus.strobe_en), 32'd0);
      prev_se = bus.strobe_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    bus.din[i*8 +: 8] = v;
  endtask

  // Waits (bounded) for an ack; reports the acked requester and dout at that time.
  task automatic wait_ack(output int who, output logic [7:0] d);
    logic seen;
    seen = 1'b0;
    who  = -1;
    d    = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (bus.ack != '0) begin
        seen = 1'b1;
        d    = bus.dout;
        for (int i = 0; i < 4; i++) begin
          if (bus.ack[i]) who = i;
        end
      end
    end
    check_eq("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic drop(input int who);
    if (who >= 0 && who < 4) bus.req[who] = 1'b0;
  endtask

  initial begin
    int         who;
    int         base;
    logic [7:0] d;
    logic [7:0] exp_d [4];

    n_tests    = 0;
    n_fail     = 0;
    pulse_cnt  = 0;
    last_pulse = '0;
    prev_se    = 1'b0;
    rst        = 1'b1;
    bus.req    = '0;
    bus.din    = '0;

    // Reset state
    do_reset();
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    check_eq("rst_se", 32'(bus.strobe_en), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);

    // Single transfer, cycle by cycle
    base = pulse_cnt;
    set_din(1, 8'hA5);
    bus.req = 4'b0010;
    step();
    check_eq("t1_gnt", 32'(bus.gnt), 32'h2);
    check_eq("t1_dout_grant", 32'(bus.dout), 32'hA5);
    check_eq("t1_se_grant", 32'(bus.strobe_en), 32'd0);
    check_eq("t1_busy", 32'(bus.busy), 32'd1);
    step();
    check_eq("t1_se_strobe", 32'(bus.strobe_en), 32'd1);
    check_eq("t1_gnt_strobe", 32'(bus.gnt), 32'h2);
    step();
    check_eq("t1_ack", 32'(bus.ack), 32'h2);
    check_eq("t1_se_ack", 32'(bus.strobe_en), 32'd0);
    check_eq("t1_pulse_cnt", 32'(pulse_cnt - base), 32'd1);
    check_eq("t1_pulse_data", 32'(last_pulse), 32'hA5);
    bus.req = 4'b0000;
    step();
    check_eq("t1_rel_gnt", 32'(bus.gnt), 32'd0);
    check_eq("t1_rel_ack", 32'(bus.ack), 32'd0);
    check_eq("t1_rel_dout", 32'(bus.dout), 32'hA5);
    check_eq("t1_rel_busy", 32'(bus.busy), 32'd1);
    step();
    check_eq("t1_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("t1_total_pulses", 32'(pulse_cnt - base), 32'd1);

    // All four requesting from ptr=0: order 0,1,2,3
    do_reset();
    base     = pulse_cnt;
    exp_d[0] = 8'h10;
    exp_d[1] = 8'h21;
    exp_d[2] = 8'h32;
    exp_d[3] = 8'h43;
    for (int i = 0; i < 4; i++) set_din(i, exp_d[i]);
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, d);
      check_eq("rr_order", 32'(who), 32'(k));
      check_eq("rr_dout", 32'(d), 32'(exp_d[k]));
      check_eq("rr_pulse_data", 32'(last_pulse), 32'(exp_d[k]));
      drop(who);
    end
    check_eq("rr_pulses", 32'(pulse_cnt - base), 32'd4);

    // Requester 2 keeps req high after its ack; requester 0 must wait
    do_reset();
    set_din(0, 8'h0A);
    set_din(2, 8'h2C);
    bus.req = 4'b0100;
    wait_ack(who, d);
    check_eq("hold_first", 32'(who), 32'd2);
    base    = pulse_cnt;
    bus.req = 4'b0101;
    for (int c = 0; c < 6; c++) step();
    check_eq("hold_gnt", 32'(bus.gnt), 32'd0);
    check_eq("hold_busy", 32'(bus.busy), 32'd1);
    check_eq("hold_no_pulse", 32'(pulse_cnt - base), 32'd0);
    bus.req = 4'b0001;
    wait_ack(who, d);
    check_eq("hold_next", 32'(who), 32'd0);
    check_eq("hold_next_dout", 32'(d), 32'h0A);
    check_eq("hold_pulses", 32'(pulse_cnt - base), 32'd1);
    drop(who);

    // din change after grant does not reach dout
    do_reset();
    set_din(0, 8'h11);
    bus.req = 4'b0001;
    step();
    check_eq("din_gnt", 32'(bus.gnt), 32'h1);
    set_din(0, 8'h22);
    wait_ack(who, d);
    check_eq("din_dout", 32'(d), 32'h11);
    check_eq("din_pulse", 32'(last_pulse), 32'h11);
    drop(who);
    step();
    step();

    // Reset during GRANT: no pulse
    base    = pulse_cnt;
    bus.req = 4'b0010;
    step();
    check_eq("rg_gnt", 32'(bus.gnt), 32'h2);
    rst     = 1'b1;
    bus.req = 4'b0000;
    step();
    rst = 1'b0;
    check_eq("rg_gnt0", 32'(bus.gnt), 32'd0);
    check_eq("rg_dout0", 32'(bus.dout), 32'd0);
    check_eq("rg_busy0", 32'(bus.busy), 32'd0);
    check_eq("rg_se0", 32'(bus.strobe_en), 32'd0);
    for (int c = 0; c < 3; c++) step();
    check_eq("rg_pulses", 32'(pulse_cnt - base), 32'd0);

    // Reset during STROBE: exactly the one pulse on the reset edge
    bus.req = 4'b0010;
    step();
    step();
    check_eq("rs_se", 32'(bus.strobe_en), 32'd1);
    rst     = 1'b1;
    bus.req = 4'b0000;
    step();
    rst = 1'b0;
    check_eq("rs_gnt0", 32'(bus.gnt), 32'd0);
    check_eq("rs_ack0", 32'(bus.ack), 32'd0);
    check_eq("rs_se0", 32'(bus.strobe_en), 32'd0);
    check_eq("rs_busy0", 32'(bus.busy), 32'd0);
    check_eq("rs_pulse_once", 32'(pulse_cnt - base), 32'd1);
    for (int c = 0; c < 4; c++) step();
    check_eq("rs_no_more", 32'(pulse_cnt - base), 32'd1);

    // ptr was 1 before the resets; requester 0 wins only if ptr cleared
    bus.req = 4'b0011;
    wait_ack(who, d);
    check_eq("rs_ptr0", 32'(who), 32'd0);
    bus.req = 4'b0000;

    // Wrap-around: after a requester-2 win, 1001 yields 3 then 0
    set_din(2, 8'h5A);
    bus.req = 4'b0100;
    wait_ack(who, d);
    check_eq("wrap_first", 32'(who), 32'd2);
    set_din(0, 8'hC0);
    set_din(3, 8'hD3);
    bus.req = 4'b1001;
    wait_ack(who, d);
    check_eq("wrap_3", 32'(who), 32'd3);
    check_eq("wrap_3_dout", 32'(d), 32'hD3);
    drop(who);
    wait_ack(who, d);
    check_eq("wrap_0", 32'(who), 32'd0);
    check_eq("wrap_0_dout", 32'(d), 32'hC0);
    drop(who);
    step();
    step();
    check_eq("end_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
